// File: rtl/lfsr_sequence_checker.sv
// Tracks a 3-bit maximal-length LFSR stream (x^3 + x^2 + 1 ordering):
// acquires lock after LOCK_COUNT consecutive predicted samples and then flywheels.
module lfsr_sequence_checker #(
  parameter int LOCK_COUNT = 3,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic [1:3]       din,
  output logic             locked,
  output logic             error,
  output logic             wrap,
  output logic [ERR_W-1:0] err_count,
  output logic             zero_seen,
  output logic [1:0]       dbg_state_o
);

  // Handshake: din is consumed only on a rising edge where din_valid=1 and rst=0;
  // there is no backpressure, and every output reflects the sample one edge later.

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [2:0]       LOCK_TARGET = 3'(LOCK_COUNT);
  localparam logic [ERR_W-1:0] ERR_ONE     = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

  function automatic logic [1:3] lfsr_next(input logic [1:3] x);
    return {x[2] ^ x[3], x[1], x[2]};
  endfunction

  state_t           state_q,  state_d;
  logic [1:3]       pred_q,   pred_d;
  logic [2:0]       match_q,  match_d;
  logic [1:0]       miss_q,   miss_d;
  logic [2:0]       phase_q,  phase_d;
  logic             locked_q, locked_d;
  logic             error_q,  error_d;
  logic             wrap_q,   wrap_d;
  logic [ERR_W-1:0] errcnt_q, errcnt_d;
  logic             zero_q,   zero_d;
  logic [2:0]       match_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SEARCH;
      pred_q   <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      phase_q  <= '0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
      wrap_q   <= 1'b0;
      errcnt_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pred_q   <= pred_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      phase_q  <= phase_d;
      locked_q <= locked_d;
      error_q  <= error_d;
      wrap_q   <= wrap_d;
      errcnt_q <= errcnt_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pred_d    = pred_q;
    match_d   = match_q;
    miss_d    = miss_q;
    phase_d   = phase_q;
    errcnt_d  = errcnt_q;
    zero_d    = zero_q;
    error_d   = 1'b0;
    wrap_d    = 1'b0;
    match_inc = match_q + 3'd1;

    if (din_valid) begin
      if (din == 3'b000) zero_d = 1'b1;

      case (state_q)
        SEARCH: begin
          if (din != 3'b000) begin
            pred_d  = lfsr_next(din);
            match_d = '0;
            state_d = VERIFY;
          end
        end

        VERIFY: begin
          if (din == pred_q) begin
            pred_d  = lfsr_next(din);
            match_d = match_inc;
            if (match_inc == LOCK_TARGET) begin
              state_d = LOCKED;
              phase_d = '0;
              miss_d  = '0;
            end
          end else if (din != 3'b000) begin
            // Mismatch before lock: restart the run from this sample, no error.
            pred_d  = lfsr_next(din);
            match_d = '0;
          end else begin
            state_d = SEARCH;
          end
        end

        LOCKED: begin
          // Prediction flywheels from itself so a single bad sample cannot derail it.
          pred_d  = lfsr_next(pred_q);
          wrap_d  = (phase_q == 3'd6);
          phase_d = (phase_q == 3'd6) ? 3'd0 : phase_q + 3'd1;
          if (din == pred_q) begin
            miss_d = '0;
          end else begin
            error_d = 1'b1;
            if (errcnt_q != ERR_MAX) errcnt_d = errcnt_q + ERR_ONE;
            miss_d = miss_q + 2'd1;
            if (miss_q == 2'd1) state_d = SEARCH;
          end
        end

        default: state_d = SEARCH;
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  assign locked      = locked_q;
  assign error       = error_q;
  assign wrap        = wrap_q;
  assign err_count   = errcnt_q;
  assign zero_seen   = zero_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/lfsr_sequence_checker.md
LFSR_SEQUENCE_CHECKER -- requirements
Module: lfsr_sequence_checker

Interface
REQ-001 The block SHALL have parameter LOCK_COUNT, default 3, giving the number of consecutive correct samples needed to declare lock (legal range 1..7).
REQ-002 The block SHALL have parameter ERR_W, default 8, giving the width of the error counter.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 din_valid  input  1  qualifies din for one cycle.
REQ-006 din  input  3 [1:3]  sample from the 3-bit LFSR; bit 1 is the MSB.
REQ-007 locked  output  1  high while in state LOCKED.
REQ-008 error  output  1  one-cycle pulse when a LOCKED-state sample mismatches.
REQ-009 wrap  output  1  one-cycle pulse each time the 7-sample period completes while locked.
REQ-010 err_count  output  ERR_W  saturating count of mismatches seen in LOCKED.
REQ-011 zero_seen  output  1  sticky flag, set on any valid all-zero sample.

Function
REQ-012 The expected successor SHALL be next(x) = {x[2]^x[3], x[1], x[2]}, giving the cycle 001->100->010->101->110->111->011->001.
REQ-013 The block SHALL use three states: SEARCH, VERIFY and LOCKED.
REQ-014 A cycle with din_valid=0 SHALL change no state, counter or prediction, and SHALL produce no pulse.
REQ-015 In SEARCH, a valid non-zero din SHALL load pred=next(din), clear match_cnt and move to VERIFY.
REQ-016 In SEARCH, a valid din=000 SHALL set zero_seen and remain in SEARCH.
REQ-017 In VERIFY, a valid din==pred SHALL increment match_cnt and load pred=next(din).
REQ-018 In VERIFY, when the incremented match_cnt equals LOCK_COUNT, the block SHALL move to LOCKED and clear phase_cnt and miss_cnt.
REQ-019 In VERIFY, a valid din!=pred SHALL resync: if din is non-zero, it loads pred=next(din), clears match_cnt and stays in VERIFY.
REQ-020 In VERIFY, a valid din!=pred with din=000 SHALL set zero_seen and move to SEARCH.
REQ-021 In LOCKED, pred SHALL always advance as pred=next(pred), even on a mismatch, so the sequence flywheels.
REQ-022 In LOCKED, a valid din==pred SHALL clear miss_cnt.
REQ-023 In LOCKED, a valid din!=pred SHALL pulse error the next cycle, increment err_count (saturating at all-ones), and increment miss_cnt.
REQ-024 In LOCKED, a mismatch that brings miss_cnt to 2 (two consecutive valid mismatches) SHALL move to SEARCH and drop locked the next cycle.
REQ-025 A mismatch in LOCKED SHALL still be counted and pulsed when it is also the unlocking sample.
REQ-026 phase_cnt (3 bits) SHALL count valid samples in LOCKED from 0 to 6 and then wrap to 0.
REQ-027 wrap SHALL pulse the cycle after phase_cnt wraps from 6 to 0, whether or not that sample matched.
REQ-028 All outputs SHALL be registered, with one-cycle latency from the sampling edge.
REQ-029 error and wrap SHALL never be high for more than one consecutive cycle per triggering sample.
REQ-030 err_count and zero_seen SHALL persist across unlock/relock and SHALL clear only on rst.

Reset
REQ-031 On rst=1 at a clock edge, the block SHALL go to SEARCH and clear pred, match_cnt, miss_cnt and phase_cnt.
REQ-032 On the same edge, locked, error, wrap, err_count and zero_seen SHALL all be 0.
REQ-033 rst SHALL take priority over din_valid; a sample presented on a reset cycle SHALL be discarded.
REQ-034 A reset applied mid-VERIFY or mid-LOCKED SHALL abort immediately, with no error or wrap pulse.

Verification
REQ-035 Lock acquisition: valid stream 001,100,010,101 on consecutive cycles -> locked=1 one cycle after the 101 edge; err_count=0.
REQ-036 Period: after lock, 7 further correct samples -> exactly one wrap pulse; error never asserted.
REQ-037 Single error: while locked, replace expected 110 with 000 -> one error pulse, err_count=1, zero_seen=1, locked stays 1; the next correct sample 111 is accepted with no error.
REQ-038 Loss of lock: two consecutive wrong samples while locked -> two error pulses, err_count=2, locked=0 after the second; a fresh correct sequence relocks after LOCK_COUNT+1 samples.
REQ-039 Gaps and resync: correct sequence with din_valid=0 bubbles inserted -> same lock timing counted in valid samples only; a mismatch in VERIFY (e.g. 001,100,111) -> no error pulse, and relock is counted from 111.
REQ-040 Reset and saturation: with ERR_W=2, drive 5 mismatches across relocks -> err_count saturates at 3; rst asserted while locked -> all outputs 0 on the next cycle.
